// File: rtl/core_fetch_pkg.sv
// ============================================================================
// Module   : core_fetch_pkg
// Purpose  : Shared definitions for the fetch front end: the next-PC source
//            priority encoding and the legal ranges of the fetch block size
//            and return-address-stack depth.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_fetch_pkg;

  // Next-PC sources, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    NPC_INT  = 3'd0,  // interrupt redirect
    NPC_TRAP = 3'd1,  // ecall / mret redirect
    NPC_BERR = 3'd2,  // branch mispredict redirect
    NPC_HOLD = 3'd3,  // stall: keep pc
    NPC_XBD  = 3'd4,  // second half of a block-straddling fetch: keep pc
    NPC_RAS  = 3'd5,  // predicted return from the RAS
    NPC_JB   = 3'd6,  // jal / jalr / predicted-taken branch target
    NPC_SEQ  = 3'd7   // sequential pc + 2 / 4
  } npc_sel_e;

  localparam int FETCH_BYTES_MIN = 8;
  localparam int FETCH_BYTES_MAX = 16;
  localparam int RAS_DEPTH_MIN   = 2;
  localparam int RAS_DEPTH_MAX   = 16;

  function automatic bit fetch_bytes_legal(input int fb);
    return (fb == FETCH_BYTES_MIN) || (fb == FETCH_BYTES_MAX);
  endfunction

  function automatic bit ras_depth_legal(input int d);
    return (d >= RAS_DEPTH_MIN) && (d <= RAS_DEPTH_MAX) && ((d & (d - 1)) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ras_stack.sv
// ============================================================================
// Module   : ras_stack
// Purpose  : Circular return-address stack. A push when full overwrites the
//            oldest entry and the count saturates at RAS_DEPTH. A push and a
//            pop together replace the top entry. Flush empties the stack and
//            wins over a same-cycle push.
// Ports    : clk, cpurst      - clock, synchronous active-high reset
//            push, push_data  - push a return address
//            pop              - pop the top entry (ignored when empty)
//            flush            - discard all entries
//            top              - current top-of-stack entry
//            count            - number of valid entries (0..RAS_DEPTH)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ras_stack
  import core_fetch_pkg::*;
#(
  parameter  int RAS_DEPTH = 4,
  localparam int RP_W      = $clog2(RAS_DEPTH)
) (
  input  logic            clk,
  input  logic            cpurst,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [31:0]     push_data,
  output logic [31:0]     top,
  output logic [RP_W:0]   count
);

  localparam logic [RP_W:0] FULL = (RP_W+1)'(RAS_DEPTH);

  logic [31:0]     mem [RAS_DEPTH];
  logic [RP_W-1:0] ptr;      // next free slot; top lives at ptr-1
  logic [RP_W-1:0] top_idx;
  logic            do_pop;

  assign top_idx = ptr - 1'b1;
  assign top     = mem[top_idx];
  assign do_pop  = pop & (count != '0);

  always_ff @(posedge clk) begin
    if (cpurst || flush) begin
      ptr   <= '0;
      count <= '0;
    end else if (push && do_pop) begin
      // top replaced in place; pointer and count unchanged
    end else if (push) begin
      ptr   <= ptr + 1'b1;
      count <= (count == FULL) ? FULL : count + 1'b1;
    end else if (do_pop) begin
      ptr   <= ptr - 1'b1;
      count <= count - 1'b1;
    end
  end

  // Entry storage carries no reset; contents are only read when count != 0.
  always_ff @(posedge clk) begin
    if (!cpurst && !flush && push) begin
      if (do_pop) mem[top_idx] <= push_data;
      else        mem[ptr]     <= push_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/genpc_ras.sv
// ============================================================================
// Module   : genpc_ras
// Purpose  : Fetch next-PC generator with return-address-stack prediction.
//            Selects the next PC from redirects, stalls, RAS, jump/branch
//            targets or sequential flow, and drives the instruction SRAM
//            block address/chip-select including the extra fetch needed for
//            an instruction straddling two fetch blocks.
// Ports    : clk, cpurst                  - clock, sync active-high reset
//            boot_addr                    - reset PC
//            fet_stall, fetch_misalign    - hold PC
//            jalr_dep                     - jalr base not yet available
//            isrv16, isjal, isjalr, isbxx - pre-decode of current instr
//            predict_bxxtaken             - static branch prediction
//            is_call, is_ret              - link-register hints
//            jb_offset, jalr_base         - target offset / jalr base
//            int_req/int_target, trap_req/trap_target,
//            branch_predict_err/de2fe_branch_target - redirects
//            ras_flush                    - clear RAS
//            pc, isram_adr, isram_cs      - fetch PC, SRAM address / select
//            cross_bd_ff, jb_ff, holdpc   - status flags
//            ras_hit, ras_count           - RAS prediction status
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module genpc_ras
  import core_fetch_pkg::*;
#(
  parameter  int FETCH_BYTES = 8,
  parameter  int RAS_DEPTH   = 4,
  localparam int FB_LG       = $clog2(FETCH_BYTES),
  localparam int RP_W        = $clog2(RAS_DEPTH)
) (
  input  logic              clk,
  input  logic              cpurst,
  input  logic [31:0]       boot_addr,
  input  logic              fet_stall,
  input  logic              fetch_misalign,
  input  logic              jalr_dep,
  input  logic              isrv16,
  input  logic              isjal,
  input  logic              isjalr,
  input  logic              isbxx,
  input  logic              predict_bxxtaken,
  input  logic              is_call,
  input  logic              is_ret,
  input  logic [31:0]       jb_offset,
  input  logic [31:0]       jalr_base,
  input  logic              int_req,
  input  logic [31:0]       int_target,
  input  logic              trap_req,
  input  logic [31:0]       trap_target,
  input  logic              branch_predict_err,
  input  logic [31:0]       de2fe_branch_target,
  input  logic              ras_flush,
  output logic [31:0]       pc,
  output logic [31-FB_LG:0] isram_adr,
  output logic              isram_cs,
  output logic              cross_bd_ff,
  output logic              jb_ff,
  output logic              holdpc,
  output logic              ras_hit,
  output logic [RP_W:0]     ras_count
);

  localparam int BA_W = 32 - FB_LG;

  generate
    if (!fetch_bytes_legal(FETCH_BYTES)) begin : g_bad_fetch_bytes
      $error("genpc_ras: FETCH_BYTES must be 8 or 16");
    end
    if (!ras_depth_legal(RAS_DEPTH)) begin : g_bad_ras_depth
      $error("genpc_ras: RAS_DEPTH must be a power of 2 from 2 to 16");
    end
  endgenerate

  logic            redirect;
  logic            jb_take;
  logic            advance;
  logic            cross_bd;
  logic            ras_flush_all;
  logic [31:0]     seq_pc;
  logic [31:0]     jb_target;
  logic [31:0]     ras_top;
  logic [31:0]     nxtpc;
  logic [BA_W-1:0] adr_q;
  npc_sel_e        npc_sel;

  assign redirect  = int_req | trap_req | branch_predict_err;
  assign jb_take   = isjal | isjalr | (isbxx & predict_bxxtaken);
  assign ras_hit   = is_ret & isjalr & (ras_count != '0) & ~cross_bd_ff;
  // A RAS hit supplies the return address, so the jalr base is not needed.
  assign holdpc    = fet_stall | fetch_misalign | (jalr_dep & ~ras_hit);
  assign advance   = ~holdpc & ~cross_bd_ff & ~redirect;
  assign seq_pc    = pc + (isrv16 ? 32'd2 : 32'd4);
  assign jb_target = (isjalr ? jalr_base : pc) + jb_offset;

  always_comb begin
    npc_sel = NPC_SEQ;
    if      (int_req)            npc_sel = NPC_INT;
    else if (trap_req)           npc_sel = NPC_TRAP;
    else if (branch_predict_err) npc_sel = NPC_BERR;
    else if (holdpc)             npc_sel = NPC_HOLD;
    else if (cross_bd_ff)        npc_sel = NPC_XBD;
    else if (ras_hit)            npc_sel = NPC_RAS;
    else if (jb_take)            npc_sel = NPC_JB;
  end

  always_comb begin
    nxtpc = seq_pc;
    case (npc_sel)
      NPC_INT:  nxtpc = int_target;
      NPC_TRAP: nxtpc = trap_target;
      NPC_BERR: nxtpc = de2fe_branch_target;
      NPC_HOLD: nxtpc = pc;
      NPC_XBD:  nxtpc = pc;
      NPC_RAS:  nxtpc = ras_top;
      NPC_JB:   nxtpc = jb_target;
      default:  nxtpc = seq_pc;
    endcase
  end

  // The last halfword of a block starts an instruction that may spill into
  // the following block, which then needs a second fetch.
  assign cross_bd = &nxtpc[FB_LG-1:1];

  always_comb begin
    isram_adr = nxtpc[31:FB_LG];
    if (cpurst)                        isram_adr = boot_addr[31:FB_LG];
    else if (cross_bd_ff && !redirect) isram_adr = pc[31:FB_LG] + BA_W'(1);
  end

  assign isram_cs = cpurst | (isram_adr != adr_q) | cross_bd;

  always_ff @(posedge clk) begin
    if (cpurst) begin
      pc          <= boot_addr;
      cross_bd_ff <= 1'b0;
      jb_ff       <= 1'b0;
      adr_q       <= boot_addr[31:FB_LG];
    end else begin
      pc          <= nxtpc;
      // Never set two cycles running, and a redirect cancels it.
      cross_bd_ff <= cross_bd & ~cross_bd_ff & ~redirect;
      jb_ff       <= ras_hit | jb_take | branch_predict_err;
      adr_q       <= isram_adr;
    end
  end

  assign ras_flush_all = ras_flush | int_req | trap_req;

  ras_stack #(
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .cpurst    (cpurst),
    .push      (is_call & advance),
    .pop       (ras_hit & advance),
    .flush     (ras_flush_all),
    .push_data (seq_pc),
    .top       (ras_top),
    .count     (ras_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_genpc_ras.sv
// ============================================================================
// Module   : tb_genpc_ras
// Purpose  : Self-checking bench for genpc_ras. Instance a uses the default
//            parameters (8-byte blocks, 4-entry RAS); instance b uses 16-byte
//            blocks and a 2-entry RAS. Both share one stimulus set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_genpc_ras;

  logic        clk = 1'b0;
  logic        cpurst;
  logic [31:0] boot_addr;
  logic        fet_stall, fetch_misalign, jalr_dep, isrv16;
  logic        isjal, isjalr, isbxx, predict_bxxtaken, is_call, is_ret;
  logic [31:0] jb_offset, jalr_base;
  logic        int_req, trap_req, branch_predict_err, ras_flush;
  logic [31:0] int_target, trap_target, de2fe_branch_target;

  logic [31:0] pc_a, pc_b;
  logic [28:0] adr_a;
  logic [27:0] adr_b;
  logic        cs_a, xff_a, jb_a, hold_a, hit_a;
  logic        cs_b, xff_b, jb_b, hold_b, hit_b;
  logic [2:0]  cnt_a;
  logic [1:0]  cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  genpc_ras u_a (
    .clk(clk), .cpurst(cpurst), .boot_addr(boot_addr), .fet_stall(fet_stall),
    .fetch_misalign(fetch_misalign), .jalr_dep(jalr_dep), .isrv16(isrv16),
    .isjal(isjal), .isjalr(isjalr), .isbxx(isbxx), .predict_bxxtaken(predict_bxxtaken),
    .is_call(is_call), .is_ret(is_ret), .jb_offset(jb_offset), .jalr_base(jalr_base),
    .int_req(int_req), .int_target(int_target), .trap_req(trap_req), .trap_target(trap_target),
    .branch_predict_err(branch_predict_err), .de2fe_branch_target(de2fe_branch_target),
    .ras_flush(ras_flush), .pc(pc_a), .isram_adr(adr_a), .isram_cs(cs_a),
    .cross_bd_ff(xff_a), .jb_ff(jb_a), .holdpc(hold_a), .ras_hit(hit_a), .ras_count(cnt_a)
  );

  genpc_ras #(.FETCH_BYTES(16), .RAS_DEPTH(2)) u_b (
    .clk(clk), .cpurst(cpurst), .boot_addr(boot_addr), .fet_stall(fet_stall),
    .fetch_misalign(fetch_misalign), .jalr_dep(jalr_dep), .isrv16(isrv16),
    .isjal(isjal), .isjalr(isjalr), .isbxx(isbxx), .predict_bxxtaken(predict_bxxtaken),
    .is_call(is_call), .is_ret(is_ret), .jb_offset(jb_offset), .jalr_base(jalr_base),
    .int_req(int_req), .int_target(int_target), .trap_req(trap_req), .trap_target(trap_target),
    .branch_predict_err(branch_predict_err), .de2fe_branch_target(de2fe_branch_target),
    .ras_flush(ras_flush), .pc(pc_b), .isram_adr(adr_b), .isram_cs(cs_b),
    .cross_bd_ff(xff_b), .jb_ff(jb_b), .holdpc(hold_b), .ras_hit(hit_b), .ras_count(cnt_b)
  );

  typedef struct {
    logic        rst, stall, jal, jalr, call, ret, dep, rv16;
    logic [31:0] off, base;
    logic [31:0] e_pc;
    logic [28:0] e_adr;
    logic        e_cs, e_xff, e_jb, e_hold, e_hit;
    logic [2:0]  e_cnt;
  } vec_t;

  function automatic vec_t mkv(
    input logic rst, stall, jal, jalr, call, ret, dep, rv16,
    input logic [31:0] off, base, e_pc, input logic [28:0] e_adr,
    input logic e_cs, e_xff, e_jb, e_hold, e_hit, input logic [2:0] e_cnt);
    vec_t v;
    v.rst = rst; v.stall = stall; v.jal = jal; v.jalr = jalr; v.call = call;
    v.ret = ret; v.dep = dep; v.rv16 = rv16; v.off = off; v.base = base;
    v.e_pc = e_pc; v.e_adr = e_adr; v.e_cs = e_cs; v.e_xff = e_xff;
    v.e_jb = e_jb; v.e_hold = e_hold; v.e_hit = e_hit; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    fet_stall = 0; fetch_misalign = 0; jalr_dep = 0; isrv16 = 0;
    isjal = 0; isjalr = 0; isbxx = 0; predict_bxxtaken = 0;
    is_call = 0; is_ret = 0; jb_offset = 0; jalr_base = 0;
    int_req = 0; trap_req = 0; branch_predict_err = 0; ras_flush = 0;
    int_target = 0; trap_target = 0; de2fe_branch_target = 0;
  endtask

  // Advance one clock and leave the bench 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[12];

  initial begin
    boot_addr = 32'h100;
    cpurst    = 1'b1;
    idle();
    repeat (2) tick();

    //            rst st jal jr cl rt dp 16 off          base         pc        adr    cs x jb h hit cnt
    vecs[0]  = mkv(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,       32'h100, 29'h20, 1, 0, 0, 0, 0, 3'd0);
    vecs[1]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,       32'h100, 29'h20, 0, 0, 0, 0, 0, 3'd0);
    vecs[2]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,       32'h104, 29'h21, 1, 0, 0, 0, 0, 3'd0);
    vecs[3]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,       32'h108, 29'h21, 0, 0, 0, 0, 0, 3'd0);
    vecs[4]  = mkv(0, 1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,       32'h10C, 29'h21, 0, 0, 0, 1, 0, 3'd0);
    vecs[5]  = mkv(0, 0, 1, 0, 1, 0, 0, 0, 32'hF4,       32'h0,       32'h10C, 29'h40, 1, 0, 0, 0, 0, 3'd0);
    vecs[6]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,       32'h200, 29'h40, 0, 0, 1, 0, 0, 3'd1);
    vecs[7]  = mkv(0, 0, 0, 1, 0, 1, 1, 0, 32'h0,        32'h999,     32'h204, 29'h22, 1, 0, 0, 0, 1, 3'd1);
    vecs[8]  = mkv(0, 0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,       32'h110, 29'h22, 0, 0, 1, 0, 0, 3'd0);
    vecs[9]  = mkv(0, 0, 0, 1, 0, 1, 0, 0, 32'h4,        32'h300,     32'h112, 29'h60, 1, 0, 0, 0, 0, 3'd0);
    vecs[10] = mkv(0, 0, 0, 1, 0, 1, 1, 0, 32'h4,        32'h300,     32'h304, 29'h60, 0, 0, 1, 1, 0, 3'd0);
    vecs[11] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,       32'h304, 29'h61, 1, 0, 1, 0, 0, 3'd0);

    for (int i = 0; i < 12; i++) begin
      idle();
      cpurst = vecs[i].rst;   fet_stall = vecs[i].stall; isjal = vecs[i].jal;
      isjalr = vecs[i].jalr;  is_call = vecs[i].call;    is_ret = vecs[i].ret;
      jalr_dep = vecs[i].dep; isrv16 = vecs[i].rv16;
      jb_offset = vecs[i].off; jalr_base = vecs[i].base;
      #3;
      chk($sformatf("v%0d pc", i),    pc_a,   vecs[i].e_pc);
      chk($sformatf("v%0d adr", i),   {3'b0, adr_a}, {3'b0, vecs[i].e_adr});
      chk($sformatf("v%0d cs", i),    {31'b0, cs_a},   {31'b0, vecs[i].e_cs});
      chk($sformatf("v%0d xbd", i),   {31'b0, xff_a},  {31'b0, vecs[i].e_xff});
      chk($sformatf("v%0d jb_ff", i), {31'b0, jb_a},   {31'b0, vecs[i].e_jb});
      chk($sformatf("v%0d hold", i),  {31'b0, hold_a}, {31'b0, vecs[i].e_hold});
      chk($sformatf("v%0d hit", i),   {31'b0, hit_a},  {31'b0, vecs[i].e_hit});
      chk($sformatf("v%0d cnt", i),   {29'b0, cnt_a},  {29'b0, vecs[i].e_cnt});
      tick();
    end

    // Block-straddling 4-byte instruction at 0x106 (8-byte blocks).
    idle(); isjal = 1; jb_offset = 32'hFFFF_FDFE; #3;
    chk("xbd jump pc", pc_a, 32'h308);
    chk("xbd jump cs", {31'b0, cs_a}, 32'd1);
    tick(); idle(); #3;
    chk("xbd pc held", pc_a, 32'h106);
    chk("xbd flag set", {31'b0, xff_a}, 32'd1);
    chk("xbd adr next block", {3'b0, adr_a}, 32'h21);
    chk("xbd cs", {31'b0, cs_a}, 32'd1);
    tick(); #3;
    chk("xbd pc still", pc_a, 32'h106);
    chk("xbd flag clear", {31'b0, xff_a}, 32'd0);
    chk("xbd adr after", {3'b0, adr_a}, 32'h21);
    tick();

    // Call then return with jalr_dep: RAS hit removes the stall.
    idle(); isjal = 1; is_call = 1; jb_offset = 32'hF6; #3;
    chk("call0 pc", pc_a, 32'h10A);
    tick(); idle(); isjal = 1; is_call = 1; jb_offset = 32'h40; #3;
    chk("call1 pc", pc_a, 32'h200);
    chk("call1 cnt", {29'b0, cnt_a}, 32'd1);
    tick(); idle(); isjalr = 1; is_ret = 1; jalr_dep = 1; jalr_base = 32'h7000; #3;
    chk("ret pc", pc_a, 32'h240);
    chk("ret hit", {31'b0, hit_a}, 32'd1);
    chk("ret hold", {31'b0, hold_a}, 32'd0);
    chk("ret adr", {3'b0, adr_a}, 32'h40);
    chk("ret cnt", {29'b0, cnt_a}, 32'd2);
    tick(); idle(); #3;
    chk("ret target pc", pc_a, 32'h204);
    chk("ret popped cnt", {29'b0, cnt_a}, 32'd1);

    // Interrupt with mispredict and call in the same cycle.
    int_req = 1; int_target = 32'h4006; branch_predict_err = 1;
    de2fe_branch_target = 32'h5000; is_call = 1; #3;
    chk("int adr", {3'b0, adr_a}, 32'h800);
    tick(); idle(); #3;
    chk("int pc", pc_a, 32'h4006);
    chk("int cnt flushed", {29'b0, cnt_a}, 32'd0);
    chk("int xbd cleared", {31'b0, xff_a}, 32'd0);

    // Reset while cross_bd_ff is set and a redirect is pending.
    tick(); idle(); isjal = 1; jb_offset = 32'hFFFF_C0FC;
    tick(); idle(); #3;
    chk("rst pre pc", pc_a, 32'h106);
    chk("rst pre xbd", {31'b0, xff_a}, 32'd1);
    cpurst = 1; branch_predict_err = 1; de2fe_branch_target = 32'h900;
    tick(); idle(); #3;
    chk("rst pc", pc_a, 32'h100);
    chk("rst xbd", {31'b0, xff_a}, 32'd0);
    chk("rst adr", {3'b0, adr_a}, 32'h20);
    chk("rst cs", {31'b0, cs_a}, 32'd1);
    tick();
    cpurst = 0;

    // Instance b: 2-entry RAS overflow then underflow, 16-byte straddle.
    idle(); isjal = 1; is_call = 1; jb_offset = 32'h100; #3;
    chk("b call0 pc", pc_b, 32'h100);
    chk("b call0 cnt", {30'b0, cnt_b}, 32'd0);
    tick(); #3;
    chk("b call1 pc", pc_b, 32'h200);
    tick(); #3;
    chk("b call2 pc", pc_b, 32'h300);
    chk("b call2 cnt", {30'b0, cnt_b}, 32'd2);
    tick(); idle(); isjalr = 1; is_ret = 1; jalr_base = 32'h800; #3;
    chk("b ret0 pc", pc_b, 32'h400);
    chk("b ret0 cnt sat", {30'b0, cnt_b}, 32'd2);
    chk("b ret0 hit", {31'b0, hit_b}, 32'd1);
    tick(); #3;
    chk("b ret1 pc", pc_b, 32'h304);
    chk("b ret1 hit", {31'b0, hit_b}, 32'd1);
    tick(); #3;
    chk("b ret2 pc", pc_b, 32'h204);
    chk("b ret2 cnt", {30'b0, cnt_b}, 32'd0);
    chk("b ret2 miss", {31'b0, hit_b}, 32'd0);
    tick(); idle(); isjal = 1; jb_offset = 32'hFFFF_F90E; #3;
    chk("b jalr path pc", pc_b, 32'h800);
    tick(); idle(); #3;
    chk("b xbd pc", pc_b, 32'h10E);
    chk("b xbd flag", {31'b0, xff_b}, 32'd1);
    chk("b xbd adr", {4'b0, adr_b}, 32'h11);
    tick(); #3;
    chk("b xbd clear", {31'b0, xff_b}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
